// File: rtl/beat_generator.sv
// Tempo-driven beat/measure sequencer with IDLE/RUN/PAUSE playback control.
// Optional macro SWING_EN alternates long (even step) and short (odd step) beats.
module beat_generator #(
  parameter int STEPS = 8,
  parameter int TW    = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [TW-1:0]            tempo,
  input  logic                     run,
  input  logic                     restart,
  output logic                     beat_pulse,
  output logic [$clog2(STEPS)-1:0] step,
  output logic                     measure_pulse,
  output logic                     playing
);

  // state | meaning
  // IDLE  | stopped at step 0, shadow period tracks tempo
  // RUN   | counting beats, pulses enabled
  // PAUSE | count/step/shadow frozen, pulses off
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int SW = $clog2(STEPS);
`ifdef SWING_EN
  localparam int CW = TW + 1;
`else
  localparam int CW = TW;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt, limit;
  logic [TW-1:0] shadow, shadow_nxt;
  logic [SW-1:0] step_nxt;
  logic          at_limit, beat;

`ifdef SWING_EN
  logic [CW-1:0] p_ext, quarter;
  assign p_ext   = {1'b0, shadow};
  assign quarter = p_ext >> 2;
  // one extra counter bit holds P + P/4 without wrapping
  assign limit   = step[0] ? (p_ext - quarter) : (p_ext + quarter);
`else
  assign limit = shadow;
`endif

  // >= rather than == keeps the counter from ever running past the period
  assign at_limit      = (count >= limit);
  assign beat          = (state == RUN) && at_limit && !restart;
  assign beat_pulse    = beat;
  assign measure_pulse = beat && (step == SW'(STEPS - 1));
  assign playing       = (state == RUN);

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    step_nxt   = step;
    shadow_nxt = shadow;
    if (restart) begin
      state_nxt  = run ? RUN : IDLE;
      count_nxt  = '0;
      step_nxt   = '0;
      shadow_nxt = tempo;
    end else begin
      case (state)
        IDLE: begin
          shadow_nxt = tempo;
          if (run) state_nxt = RUN;
        end
        RUN: begin
          if (at_limit) begin
            count_nxt  = '0;
            step_nxt   = step + 1'b1;
            shadow_nxt = tempo;
          end else begin
            count_nxt = count + 1'b1;
          end
          if (!run) state_nxt = PAUSE;
        end
        PAUSE: begin
          if (run) state_nxt = RUN;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      step   <= '0;
      shadow <= '0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      step   <= step_nxt;
      shadow <= shadow_nxt;
    end
  end

endmodule

// File: tb/tb_beat_generator.sv
// Bench for beat_generator: cycle-by-cycle model compare plus directed timing checks.
module tb_beat_generator;
  localparam int STEPS = 8;
  localparam int TW    = 22;
  localparam int SW    = $clog2(STEPS);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          restart = 1'b0;
  logic [TW-1:0] tempo = '0;
  logic          beat_pulse, measure_pulse, playing;
  logic [SW-1:0] step;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit checking = 1'b0;

  // model: mode 0 idle, 1 playing, 2 paused; elapsed = cycles spent in current beat
  int m_mode = 0, m_elapsed = 0, m_step = 0, m_period = 0;
  bit exp_beat, exp_meas;

  beat_generator #(.STEPS(STEPS), .TW(TW)) dut (
    .clk(clk), .rst(rst), .tempo(tempo), .run(run), .restart(restart),
    .beat_pulse(beat_pulse), .step(step), .measure_pulse(measure_pulse), .playing(playing)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int beat_len(input int p, input int s);
`ifdef SWING_EN
    if (s % 2 == 0) return p + p / 4 + 1;
    else            return p - p / 4 + 1;
`else
    return p + 1;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_beat = (m_mode == 1) && (m_elapsed == beat_len(m_period, m_step) - 1) && !restart;
    exp_meas = exp_beat && (m_step == STEPS - 1);
    if (checking) begin
      check("model beat_pulse", 32'(beat_pulse), 32'(exp_beat));
      check("model measure_pulse", 32'(measure_pulse), 32'(exp_meas));
      check("model step", 32'(step), 32'(m_step));
      check("model playing", 32'(playing), 32'(m_mode == 1));
    end
    if (rst) begin
      checking  = 1'b1;
      m_mode    = 0;
      m_elapsed = 0;
      m_step    = 0;
      m_period  = 0;
    end else if (restart) begin
      m_mode    = run ? 1 : 0;
      m_elapsed = 0;
      m_step    = 0;
      m_period  = int'(tempo);
    end else if (m_mode == 0) begin
      m_period = int'(tempo);
      if (run) m_mode = 1;
    end else if (m_mode == 1) begin
      if (exp_beat) begin
        m_elapsed = 0;
        m_step    = (m_step + 1) % STEPS;
        m_period  = int'(tempo);
      end else begin
        m_elapsed++;
      end
      if (!run) m_mode = 2;
    end else begin
      if (run) m_mode = 1;
    end
  end

  task automatic to_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input int t, output int c0);
    @(posedge clk); #1;
    rst = 1'b1; run = 1'b0; restart = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; tempo = TW'(t); run = 1'b1;
    c0 = cyc;
  endtask

  task automatic wait_beat(input string name, output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (beat_pulse === 1'b1) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      total++;
      bad++;
      $display("FAIL %s: no beat_pulse within 200 cycles", name);
    end
  endtask

  initial begin
    int c0, b1, b2, b3, b;

    @(posedge clk); #1;
    @(negedge clk);
    check("reset beat_pulse", 32'(beat_pulse), 0);
    check("reset measure_pulse", 32'(measure_pulse), 0);
    check("reset step", 32'(step), 0);
    check("reset playing", 32'(playing), 0);

    // tempo 3: beats on RUN cycles 4, 8, 12
    start(3, c0);
    wait_beat("t3 beat1", b1);
    check("t3 beat1 offset", 32'(b1 - c0), 4);
    check("t3 playing", 32'(playing), 1);
    wait_beat("t3 beat2", b2);
    check("t3 beat2 offset", 32'(b2 - c0), 8);
    wait_beat("t3 beat3", b3);
    check("t3 beat3 offset", 32'(b3 - c0), 12);
    @(negedge clk);
    check("t3 step after 3 beats", 32'(step), 3);

    // tempo 1: 8th beat wraps the measure
    start(1, c0);
    for (int i = 1; i <= 8; i++) wait_beat("t1 beat", b);
    check("t1 beat8 offset", 32'(b - c0), 16);
    check("t1 measure_pulse on beat8", 32'(measure_pulse), 1);
    check("t1 step on beat8", 32'(step), 7);
    @(negedge clk);
    check("t1 step after wrap", 32'(step), 0);

    // tempo 5: pause at count 2 for 10 cycles
    start(5, c0);
    to_cycle(c0 + 3);
    run = 1'b0;
    to_cycle(c0 + 13);
    run = 1'b1;
    wait_beat("pause resume beat", b);
    check("pause resume offset", 32'(b - (c0 + 13)), 3);

    // tempo 9 -> 2 mid-beat, then restart exactly on a beat cycle
    start(9, c0);
    to_cycle(c0 + 5);
    tempo = TW'(2);
    wait_beat("tempo change beat1", b1);
    check("tempo change beat1 offset", 32'(b1 - c0), 10);
    wait_beat("tempo change beat2", b2);
    check("tempo change spacing", 32'(b2 - b1), 3);
    to_cycle(b2 + 3);
    restart = 1'b1;
    @(negedge clk);
    check("restart suppresses beat", 32'(beat_pulse), 0);
    to_cycle(b2 + 4);
    restart = 1'b0;
    @(negedge clk);
    check("restart step cleared", 32'(step), 0);
    wait_beat("post restart beat", b);
    check("post restart offset", 32'(b - (b2 + 3)), 3);

    // restart with run low returns to idle
    to_cycle(b + 2);
    run = 1'b0;
    restart = 1'b1;
    to_cycle(b + 3);
    restart = 1'b0;
    @(negedge clk);
    check("restart idle playing", 32'(playing), 0);
    to_cycle(b + 6);
    run = 1'b1;
    to_cycle(b + 12);

    // reset in the middle of a measure
    start(1, c0);
    to_cycle(c0 + 6);
    rst = 1'b1;
    to_cycle(c0 + 7);
    rst = 1'b0;
    run = 1'b0;
    @(negedge clk);
    check("midrun rst beat_pulse", 32'(beat_pulse), 0);
    check("midrun rst measure_pulse", 32'(measure_pulse), 0);
    check("midrun rst step", 32'(step), 0);
    check("midrun rst playing", 32'(playing), 0);

    // tempo 0: a beat on every RUN cycle
    start(0, c0);
    wait_beat("t0 beat1", b1);
    wait_beat("t0 beat2", b2);
    check("t0 beat1 offset", 32'(b1 - c0), 1);
    check("t0 spacing", 32'(b2 - b1), 1);

`ifdef SWING_EN
    start(7, c0);
    wait_beat("swing beat1", b1);
    wait_beat("swing beat2", b2);
    wait_beat("swing beat3", b3);
    check("swing first offset", 32'(b1 - c0), 9);
    check("swing short gap", 32'(b2 - b1), 7);
    check("swing long gap", 32'(b3 - b2), 9);
`endif

    to_cycle(cyc + 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
